dmem_arbiter: RTL and testbench

Two-port arbiter placed in front of the single-port data memory (combinational read, write on rising clock edge). It shares the memory between the core load/store unit (port 0) and a loader/debug master (port 1). It grants one access per cycle, drives the memory write-enable, address and write data, and returns registered read data with a valid strobe one cycle after grant. A configurable policy selects round-robin or port-0 priority with a starvation guard for port 1.

---
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-memory masters, the arbiter and the memory.
// The arbiter uses the slave side; the requesters and the memory use the master side.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req0,    req1;
    logic                  we0,     we1;
    logic [ADDR_WIDTH-1:0] addr0,   addr1;
    logic [DATA_WIDTH-1:0] wdata0,  wdata1;
    logic                  gnt0,    gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0,  rdata1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: combinational grant, one access per cycle,
// read data registered one cycle after the grant edge; a denied requester simply holds its request.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic                  gnt0, gnt1;
    logic                  last_gnt_q, last_gnt_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // last_gnt_q = 1 means port 1 was served last, so port 0 wins the next tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.req0 && bus.req1) begin
                if (FIXED_PRIO != 0) begin
                    if (wait_cnt_q == WAIT_LIMIT) gnt1 = 1'b1;
                    else                          gnt0 = 1'b1;
                end else if (last_gnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0)      last_gnt_d = 1'b0;
        else if (gnt1) last_gnt_d = 1'b1;

        wait_cnt_d = '0;
        if (FIXED_PRIO != 0 && bus.req1 && !gnt1)
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 4'd1;

        rvalid0_d = gnt0 & ~bus.we0;
        rvalid1_d = gnt1 & ~bus.we1;
        rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            wait_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Idle cycles leave the address/data mux on port 0; the write enable is what matters
    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_we    = (gnt0 & bus.we0) | (gnt1 & bus.we1);
    assign bus.mem_addr  = gnt1 ? bus.addr1  : bus.addr0;
    assign bus.mem_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin instance and one fixed-priority instance,
// each in front of its own small behavioural memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_rr ();
    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_fp ();

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIXED_PRIO(0), .MAX_WAIT(4))
        dut_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIXED_PRIO(1), .MAX_WAIT(4))
        dut_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave));

    logic [31:0] mem_rr [64] = '{default: '0};
    logic [31:0] mem_fp [64] = '{default: '0};

    assign bus_rr.mem_rdata = mem_rr[bus_rr.mem_addr[5:0]];
    assign bus_fp.mem_rdata = mem_fp[bus_fp.mem_addr[5:0]];

    always @(posedge clk) begin
        if (bus_rr.mem_we) mem_rr[bus_rr.mem_addr[5:0]] <= bus_rr.mem_wdata;
        if (bus_fp.mem_we) mem_fp[bus_fp.mem_addr[5:0]] <= bus_fp.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rr(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                            input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        bus_rr.req0 = r0; bus_rr.we0 = w0; bus_rr.addr0 = a0; bus_rr.wdata0 = d0;
        bus_rr.req1 = r1; bus_rr.we1 = w1; bus_rr.addr1 = a1; bus_rr.wdata1 = d1;
    endtask

    task automatic drive_fp(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                            input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        bus_fp.req0 = r0; bus_fp.we0 = w0; bus_fp.addr0 = a0; bus_fp.wdata0 = d0;
        bus_fp.req1 = r1; bus_fp.we1 = w1; bus_fp.addr1 = a1; bus_fp.wdata1 = d1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive_rr(1, 1, 32'd7, 32'h1234_5678, 1, 1, 32'd8, 32'h8765_4321);
        drive_fp(1, 0, 32'd7, 32'h0, 1, 0, 32'd8, 32'h0);
        #2;
        total++; if (bus_rr.gnt0 !== 1'b0 || bus_rr.gnt1 !== 1'b0)
            $display("FAIL reset_gnt_rr: got %b%b want 00", bus_rr.gnt0, bus_rr.gnt1); else passed++;
        total++; if (bus_fp.gnt0 !== 1'b0 || bus_fp.gnt1 !== 1'b0)
            $display("FAIL reset_gnt_fp: got %b%b want 00", bus_fp.gnt0, bus_fp.gnt1); else passed++;
        total++; if (bus_rr.mem_we !== 1'b0)
            $display("FAIL reset_mem_we: got %b want 0", bus_rr.mem_we); else passed++;
        tick();
        total++; if (bus_rr.rvalid0 !== 1'b0 || bus_rr.rvalid1 !== 1'b0 || bus_fp.rvalid0 !== 1'b0 || bus_fp.rvalid1 !== 1'b0)
            $display("FAIL reset_rvalid: got rr %b%b fp %b%b want 0", bus_rr.rvalid0, bus_rr.rvalid1, bus_fp.rvalid0, bus_fp.rvalid1); else passed++;
        total++; if (bus_rr.rdata0 !== 32'h0 || bus_rr.rdata1 !== 32'h0)
            $display("FAIL reset_rdata: got %h %h want 0", bus_rr.rdata0, bus_rr.rdata1); else passed++;
        total++; if (mem_rr[7] !== 32'h0)
            $display("FAIL reset_no_write: got %h want 0", mem_rr[7]); else passed++;
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        drive_fp(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_port();
        drive_rr(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0);
        #1;
        total++; if (bus_rr.gnt0 !== 1'b1 || bus_rr.mem_we !== 1'b1 || bus_rr.mem_addr !== 32'd5)
            $display("FAIL single_wr_gnt: got gnt0=%b we=%b addr=%h want 1 1 5", bus_rr.gnt0, bus_rr.mem_we, bus_rr.mem_addr); else passed++;
        tick();
        total++; if (bus_rr.rvalid0 !== 1'b0 || mem_rr[5] !== 32'hDEAD_BEEF)
            $display("FAIL single_wr_done: got rvalid0=%b mem=%h want 0 deadbeef", bus_rr.rvalid0, mem_rr[5]); else passed++;
        drive_rr(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0);
        #1;
        total++; if (bus_rr.gnt0 !== 1'b1 || bus_rr.mem_we !== 1'b0)
            $display("FAIL single_rd_gnt: got gnt0=%b we=%b want 1 0", bus_rr.gnt0, bus_rr.mem_we); else passed++;
        tick();
        total++; if (bus_rr.rvalid0 !== 1'b1 || bus_rr.rdata0 !== 32'hDEAD_BEEF)
            $display("FAIL single_rd_data: got rvalid0=%b rdata0=%h want 1 deadbeef", bus_rr.rvalid0, bus_rr.rdata0); else passed++;
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
        total++; if (bus_rr.rvalid0 !== 1'b0 || bus_rr.rdata0 !== 32'hDEAD_BEEF)
            $display("FAIL single_rd_hold: got rvalid0=%b rdata0=%h want 0 deadbeef", bus_rr.rvalid0, bus_rr.rdata0); else passed++;
    endtask

    task automatic test_round_robin();
        drive_rr(1, 1, 32'd10, 32'hA0A0_A0A0, 0, 0, 32'd0, 32'd0);
        tick();
        drive_rr(0, 0, 32'd0, 32'd0, 1, 1, 32'd11, 32'hB1B1_B1B1);
        tick();
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            logic exp1;
            exp1 = (i % 2 == 1);
            drive_rr(1, 0, 32'd10, 32'd0, 1, 0, 32'd11, 32'd0);
            #1;
            total++; if (bus_rr.gnt0 !== ~exp1 || bus_rr.gnt1 !== exp1)
                $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, bus_rr.gnt0, bus_rr.gnt1, ~exp1, exp1); else passed++;
            tick();
            total++; if (bus_rr.rvalid0 !== ~exp1 || bus_rr.rvalid1 !== exp1)
                $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", i, bus_rr.rvalid0, bus_rr.rvalid1, ~exp1, exp1); else passed++;
            total++; if ((exp1 ? bus_rr.rdata1 : bus_rr.rdata0) !== (exp1 ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0))
                $display("FAIL rr_rdata[%0d]: got %h want %h", i, exp1 ? bus_rr.rdata1 : bus_rr.rdata0, exp1 ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0); else passed++;
        end
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_starvation_guard();
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            logic exp1;
            exp1 = (i % 5 == 4);
            drive_fp(1, 0, 32'd0, 32'd0, 1, 0, 32'd1, 32'd0);
            #1;
            total++; if (bus_fp.gnt0 !== ~exp1 || bus_fp.gnt1 !== exp1)
                $display("FAIL starve_gnt[%0d]: got %b%b want %b%b", i, bus_fp.gnt0, bus_fp.gnt1, ~exp1, exp1); else passed++;
            tick();
        end
        drive_fp(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_cross_port();
        drive_rr(0, 0, 32'd0, 32'd0, 1, 1, 32'd12, 32'h0000_0042);
        #1;
        total++; if (bus_rr.gnt1 !== 1'b1 || bus_rr.mem_addr !== 32'd12 || bus_rr.mem_wdata !== 32'h42)
            $display("FAIL xport_wr: got gnt1=%b addr=%h wd=%h want 1 c 42", bus_rr.gnt1, bus_rr.mem_addr, bus_rr.mem_wdata); else passed++;
        tick();
        drive_rr(1, 0, 32'd12, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
        total++; if (bus_rr.rvalid0 !== 1'b1 || bus_rr.rdata0 !== 32'h0000_0042)
            $display("FAIL xport_rd: got rvalid0=%b rdata0=%h want 1 00000042", bus_rr.rvalid0, bus_rr.rdata0); else passed++;
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset_mid_write();
        drive_rr(0, 0, 32'd0, 32'd0, 1, 1, 32'd3, 32'h1111_1111);
        tick();
        drive_rr(0, 0, 32'd0, 32'd0, 1, 1, 32'd3, 32'h9999_9999);
        #1;
        total++; if (bus_rr.gnt1 !== 1'b1)
            $display("FAIL midrst_pre_gnt: got %b want 1", bus_rr.gnt1); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus_rr.gnt1 !== 1'b0 || bus_rr.mem_we !== 1'b0)
            $display("FAIL midrst_kill: got gnt1=%b we=%b want 0 0", bus_rr.gnt1, bus_rr.mem_we); else passed++;
        tick();
        total++; if (mem_rr[3] !== 32'h1111_1111 || bus_rr.rvalid1 !== 1'b0 || bus_rr.gnt1 !== 1'b0)
            $display("FAIL midrst_held: got mem=%h rvalid1=%b gnt1=%b want 11111111 0 0", mem_rr[3], bus_rr.rvalid1, bus_rr.gnt1); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus_rr.gnt1 !== 1'b1)
            $display("FAIL midrst_retry_gnt: got %b want 1", bus_rr.gnt1); else passed++;
        tick();
        total++; if (mem_rr[3] !== 32'h9999_9999)
            $display("FAIL midrst_retry_wr: got %h want 99999999", mem_rr[3]); else passed++;
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
    endtask

    // Random requests on both instances against a transaction-level model: pending requests,
    // a reference memory image, and the tie-break rule of each policy.
    task automatic test_random();
        bit          pend [2][2];
        bit          pwe  [2][2];
        logic [31:0] pa   [2][2];
        logic [31:0] pd   [2][2];
        logic [31:0] ref_mem [2][64];
        logic [31:0] exp_rd  [2][2];
        bit          exp_rv  [2][2];
        int          rr_last_port;
        int          fp_denied;
        int          g [2];

        for (int i = 0; i < 64; i++) begin
            ref_mem[0][i] = mem_rr[i];
            ref_mem[1][i] = mem_fp[i];
        end
        pulse_reset();
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < 2; p++) begin
                pend[b][p] = 0; exp_rd[b][p] = 32'h0;
            end
        rr_last_port = 1;
        fp_denied    = 0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int b = 0; b < 2; b++)
                for (int p = 0; p < 2; p++)
                    if (!pend[b][p] && $urandom_range(0, 9) < 6) begin
                        pend[b][p] = 1;
                        pwe[b][p]  = 1'($urandom_range(0, 1));
                        pa[b][p]   = 32'($urandom_range(0, 15));
                        pd[b][p]   = $urandom;
                    end
            drive_rr(pend[0][0], pwe[0][0], pa[0][0], pd[0][0], pend[0][1], pwe[0][1], pa[0][1], pd[0][1]);
            drive_fp(pend[1][0], pwe[1][0], pa[1][0], pd[1][0], pend[1][1], pwe[1][1], pa[1][1], pd[1][1]);

            for (int b = 0; b < 2; b++) begin
                if (pend[b][0] && pend[b][1]) begin
                    if (b == 0) g[b] = (rr_last_port == 0) ? 1 : 0;
                    else        g[b] = (fp_denied == 4) ? 1 : 0;
                end else if (pend[b][0]) g[b] = 0;
                else if (pend[b][1])     g[b] = 1;
                else                     g[b] = -1;
            end
            #1;
            total++; if (bus_rr.gnt0 !== (g[0] == 0) || bus_rr.gnt1 !== (g[0] == 1))
                $display("FAIL rand_rr_gnt[%0d]: got %b%b want port %0d", cyc, bus_rr.gnt0, bus_rr.gnt1, g[0]); else passed++;
            total++; if (bus_fp.gnt0 !== (g[1] == 0) || bus_fp.gnt1 !== (g[1] == 1))
                $display("FAIL rand_fp_gnt[%0d]: got %b%b want port %0d", cyc, bus_fp.gnt0, bus_fp.gnt1, g[1]); else passed++;
            tick();

            if (pend[1][1] && g[1] != 1) fp_denied = (fp_denied < 4) ? fp_denied + 1 : 4;
            else                         fp_denied = 0;
            if (g[0] >= 0) rr_last_port = g[0];
            for (int b = 0; b < 2; b++) begin
                exp_rv[b][0] = 0;
                exp_rv[b][1] = 0;
                if (g[b] >= 0) begin
                    if (pwe[b][g[b]]) ref_mem[b][pa[b][g[b]][5:0]] = pd[b][g[b]];
                    else begin
                        exp_rv[b][g[b]] = 1;
                        exp_rd[b][g[b]] = ref_mem[b][pa[b][g[b]][5:0]];
                    end
                    pend[b][g[b]] = 0;
                end
            end
            total++; if (bus_rr.rvalid0 !== exp_rv[0][0] || bus_rr.rvalid1 !== exp_rv[0][1])
                $display("FAIL rand_rr_rvalid[%0d]: got %b%b want %b%b", cyc, bus_rr.rvalid0, bus_rr.rvalid1, exp_rv[0][0], exp_rv[0][1]); else passed++;
            total++; if (bus_rr.rdata0 !== exp_rd[0][0] || bus_rr.rdata1 !== exp_rd[0][1])
                $display("FAIL rand_rr_rdata[%0d]: got %h %h want %h %h", cyc, bus_rr.rdata0, bus_rr.rdata1, exp_rd[0][0], exp_rd[0][1]); else passed++;
            total++; if (bus_fp.rvalid0 !== exp_rv[1][0] || bus_fp.rvalid1 !== exp_rv[1][1])
                $display("FAIL rand_fp_rvalid[%0d]: got %b%b want %b%b", cyc, bus_fp.rvalid0, bus_fp.rvalid1, exp_rv[1][0], exp_rv[1][1]); else passed++;
            total++; if (bus_fp.rdata0 !== exp_rd[1][0] || bus_fp.rdata1 !== exp_rd[1][1])
                $display("FAIL rand_fp_rdata[%0d]: got %h %h want %h %h", cyc, bus_fp.rdata0, bus_fp.rdata1, exp_rd[1][0], exp_rd[1][1]); else passed++;
        end
        drive_rr(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        drive_fp(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_starvation_guard();
        test_cross_port();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
